// File: rtl/serial_chunk_adder_pkg.sv
// Shared types for the chunk-serial adder: controller states.
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its MSB
// so the caller can form a two's-complement overflow flag.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign s     = total[CHUNK-1:0];
    assign co    = total[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign c_msb = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + ci computed CHUNK bits per clock with a
// registered inter-chunk carry, valid/ready on both sides.
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              co_q, co_d, ovf_q, ovf_d;

    logic [CHUNK-1:0]  ch_s;
    logic              ch_co, ch_cmsb;
    logic              accept;

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .ci    (carry_q),
        .s     (ch_s),
        .co    (ch_co),
        .c_msb (ch_cmsb)
    );

    // out_ready feeds in_ready combinationally so a drained result and a new
    // operand pair can be exchanged on the same edge.
    assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = ch_co;
                cnt_d   = cnt_q + CW'(1);
                // LSB chunk enters first and ends up at the bottom after NCHUNK shifts.
                sum_d   = (sum_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    co_d    = ch_co;
                    ovf_d   = ch_cmsb ^ ch_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench: three configurations (32/8, 32/32, 8/1) checked against
// an arithmetic reference model.
module tb_serial_chunk_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Instance A: WIDTH=32, CHUNK=8
    logic        a_iv = 0, a_ir, a_ov, a_or = 0, a_ci = 0, a_co, a_ovf;
    logic [31:0] a_a = '0, a_b = '0, a_sum;
    // Instance B: WIDTH=32, CHUNK=32
    logic        b_iv = 0, b_ir, b_ov, b_or = 0, b_ci = 0, b_co, b_ovf;
    logic [31:0] b_a = '0, b_b = '0, b_sum;
    // Instance C: WIDTH=8, CHUNK=1
    logic        c_iv = 0, c_ir, c_ov, c_or = 0, c_ci = 0, c_co, c_ovf;
    logic [7:0]  c_a = '0, c_b = '0, c_sum;

    serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .a(a_a), .b(a_b), .ci(a_ci),
        .out_valid(a_ov), .out_ready(a_or), .sum(a_sum), .co(a_co), .ovf(a_ovf));
    serial_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .a(b_a), .b(b_b), .ci(b_ci),
        .out_valid(b_ov), .out_ready(b_or), .sum(b_sum), .co(b_co), .ovf(b_ovf));
    serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .a(c_a), .b(c_b), .ci(c_ci),
        .out_valid(c_ov), .out_ready(c_or), .sum(c_sum), .co(c_co), .ovf(c_ovf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, co, sum}; overflow when same-signed operands yield a different sign.
    function automatic logic [33:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + 33'(c);
        v = (x[31] == y[31]) && (t[31] != x[31]);
        return {v, t[32], t[31:0]};
    endfunction

    function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + 9'(c);
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {v, t[8], t[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [31:0] x, input logic [31:0] y, input logic c);
        int n = 0;
        a_a = x; a_b = y; a_ci = c; a_iv = 1'b1;
        #1;
        while (!a_ir && n < 20) begin tick(); n++; end
        chk("A_in_ready_before_accept", 32'(a_ir), 32'd1);
        tick();
        a_iv = 1'b0;
        a_a = $urandom; a_b = $urandom; a_ci = 1'($urandom);
    endtask

    task automatic wait_a(input logic [31:0] x, input logic [31:0] y, input logic c, input int lat_exp);
        int lat = 0;
        logic [33:0] r;
        while (!a_ov && lat < 50) begin tick(); lat++; end
        r = ref32(x, y, c);
        chk("A_latency", 32'(lat), 32'(lat_exp));
        chk("A_sum", a_sum, r[31:0]);
        chk("A_co", 32'(a_co), 32'(r[32]));
        chk("A_ovf", 32'(a_ovf), 32'(r[33]));
    endtask

    task automatic release_a();
        a_or = 1'b1;
        tick();
        a_or = 1'b0;
    endtask

    task automatic op_a(input logic [31:0] x, input logic [31:0] y, input logic c);
        start_a(x, y, c);
        wait_a(x, y, c, 4);
        release_a();
    endtask

    task automatic op_b(input logic [31:0] x, input logic [31:0] y, input logic c);
        int lat = 0;
        logic [33:0] r;
        b_a = x; b_b = y; b_ci = c; b_iv = 1'b1;
        #1;
        chk("B_in_ready", 32'(b_ir), 32'd1);
        tick();
        b_iv = 1'b0;
        while (!b_ov && lat < 20) begin tick(); lat++; end
        r = ref32(x, y, c);
        chk("B_latency", 32'(lat), 32'd1);
        chk("B_sum", b_sum, r[31:0]);
        chk("B_co", 32'(b_co), 32'(r[32]));
        chk("B_ovf", 32'(b_ovf), 32'(r[33]));
        b_or = 1'b1;
        tick();
        b_or = 1'b0;
    endtask

    task automatic op_c(input logic [7:0] x, input logic [7:0] y, input logic c, input int hold);
        int lat = 0;
        logic [9:0] r;
        c_a = x; c_b = y; c_ci = c; c_iv = 1'b1;
        #1;
        chk("C_in_ready", 32'(c_ir), 32'd1);
        tick();
        c_iv = 1'b0;
        c_a = 8'($urandom); c_b = 8'($urandom);
        while (!c_ov && lat < 40) begin tick(); lat++; end
        for (int h = 0; h < hold; h++) tick();
        r = ref8(x, y, c);
        chk("C_latency", 32'(lat), 32'd8);
        chk("C_valid_held", 32'(c_ov), 32'd1);
        chk("C_sum", 32'(c_sum), 32'(r[7:0]));
        chk("C_co", 32'(c_co), 32'(r[8]));
        chk("C_ovf", 32'(c_ovf), 32'(r[9]));
        c_or = 1'b1;
        tick();
        c_or = 1'b0;
    endtask

    initial begin
        logic [31:0] held_sum;
        logic        held_co, held_ovf;
        int          lat;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(a_ir), 32'd0);
        chk("rst_out_valid", 32'(a_ov), 32'd0);
        chk("rst_sum", a_sum, 32'd0);
        chk("rst_co_ovf", {30'd0, a_co, a_ovf}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(a_ir), 32'd1);

        // Directed cases, 32/8
        op_a(32'h0000_0001, 32'h0000_0002, 1'b0);
        op_a(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        op_a(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        op_a(32'h00FF_00FF, 32'h0001_0001, 1'b1);
        op_a(32'h8000_0000, 32'h8000_0000, 1'b0);

        // Backpressure, then same-edge drain + accept
        start_a(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_a(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 4);
        held_sum = a_sum; held_co = a_co; held_ovf = a_ovf;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", 32'(a_ov), 32'd1);
            chk("bp_in_ready", 32'(a_ir), 32'd0);
            chk("bp_sum_stable", a_sum, held_sum);
            chk("bp_flags_stable", {30'd0, a_co, a_ovf}, {30'd0, held_co, held_ovf});
        end
        a_a = 32'd5; a_b = 32'd6; a_ci = 1'b0; a_iv = 1'b1; a_or = 1'b1;
        #1;
        chk("bp_in_ready_comb", 32'(a_ir), 32'd1);
        tick();
        a_iv = 1'b0; a_or = 1'b0;
        chk("bp_reaccept_busy", 32'(a_ov), 32'd0);
        wait_a(32'd5, 32'd6, 1'b0, 4);
        release_a();

        // Reset while BUSY at count=2
        start_a(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(a_ov), 32'd0);
        chk("mid_rst_sum", a_sum, 32'd0);
        chk("mid_rst_flags", {30'd0, a_co, a_ovf}, 32'd0);
        chk("mid_rst_in_ready", 32'(a_ir), 32'd0);
        tick();
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 6; i++) begin tick(); lat += int'(a_ov); end
        chk("mid_rst_no_result", 32'(lat), 32'd0);
        chk("mid_rst_idle_ready", 32'(a_ir), 32'd1);
        op_a(32'd10, 32'd20, 1'b0);

        // Random, 32/8
        for (int i = 0; i < 20; i++) op_a($urandom, $urandom, 1'($urandom));

        // Single-chunk configuration
        op_b(32'h8000_0000, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 10; i++) op_b($urandom, $urandom, 1'($urandom));

        // Bit-serial configuration, 1000 random ops with random backpressure
        for (int i = 0; i < 1000; i++)
            op_c(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using a registered carry between chunks. It trades latency for area against a single-cycle ripple adder. It adds valid/ready handshakes on both the input and the output side, and produces unsigned carry-out and signed overflow flags. It sits between operand producers and result consumers in arithmetic datapaths that can tolerate multi-cycle latency.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of CHUNK (elaboration-time assertion).
CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK (localparam), WIDTH/CHUNK, cycles spent in BUSY.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a, b, ci are valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry-in
out_valid  output  1  sum, co and ovf are valid
out_ready  input  1  consumer accepts the result this cycle
sum  output  WIDTH  a + b + ci, modulo 2^WIDTH
co  output  1  unsigned carry-out of bit WIDTH-1
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, chunk counter=0, carry reg=0, operand regs=0, sum=0, co=0, ovf=0, out_valid=0. in_ready is forced to 0 while rst is high.
- States:
  - IDLE: in_ready=1. On in_valid, capture a, b and ci into registers, set count=0 and go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle:
    - add the low CHUNK bits of the A and B shift registers plus the carry reg;
    - shift the CHUNK result bits into the top of the sum shift register (LSB chunk first);
    - shift A and B right by CHUNK;
    - store the chunk carry-out into the carry reg;
    - count++.
  - BUSY, final chunk (count==NCHUNK-1): latch co = chunk carry-out and ovf = carry into bit CHUNK-1 of the chunk XOR chunk carry-out. Go to DONE.
  - DONE: out_valid=1. sum, co and ovf are held stable until out_ready=1.
- DONE exit on out_ready=1:
  - in_valid=0: go to IDLE.
  - in_valid=1: accept the new operands in the same cycle and go directly to BUSY. in_ready = (state==IDLE) | (state==DONE & out_ready); this is a combinational path from out_ready to in_ready.
- Latency: operands accepted at edge k give out_valid=1 after edge k+NCHUNK.
- Throughput: back-to-back results every NCHUNK+1 cycles.
- Operand stability: a, b and ci are sampled only on the accepting edge. Changes while BUSY or DONE have no effect.
- Handshake rules: out_valid never drops without out_ready, and the result never changes while out_valid=1 and out_ready=0. in_valid while in_ready=0 is ignored; the producer must hold its operands.
- NCHUNK==1: exactly one BUSY cycle; ovf and co are computed from the full-width add.
- Width rules: all chunk arithmetic is CHUNK+1 bits wide, and the MSB is the carry. No sign extension; sum wraps modulo 2^WIDTH.
- Reset mid-operation: the in-flight operation is aborted and no out_valid is issued. After rst deassertion the block is in IDLE with in_ready=1 the next cycle.
- out_ready asserted outside DONE is ignored.

Decomposition:
- Package serial_chunk_adder_pkg: state_t enum {IDLE, BUSY, DONE} (2-bit).
- Sub-module adder_chunk: combinational, parametrised CHUNK-bit ripple adder.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb (carry into bit CHUNK-1) for overflow.
  - The top level instantiates it once and handles all sequencing.

Test Plan:
1. WIDTH=32, CHUNK=8: a=0x00000001, b=0x00000002, ci=0 -> sum=0x00000003, co=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
2. a=0xFFFFFFFF, b=0x00000001, ci=0 -> sum=0x00000000, co=1, ovf=0. Checks carry propagation across all 4 chunks.
3. a=0x7FFFFFFF, b=0x00000001, ci=0 -> sum=0x80000000, co=0, ovf=1. Then a=0x00FF00FF, b=0x00010001, ci=1 -> sum=0x01000101, co=0, ovf=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, co and ovf stay stable, out_valid=1, in_ready=0. Then assert out_ready=1 with in_valid=1 (a=5, b=6) -> the new operands are accepted on that edge, and out_valid with sum=11 appears 4 cycles later.
5. Assert rst while BUSY at count=2 -> out_valid stays 0 and all outputs return to 0. After release, in_ready=1. The next op a=10, b=20 gives sum=30.
6. WIDTH=32, CHUNK=32: a=0x80000000, b=0x80000000, ci=1 -> sum=0x00000001, co=1, ovf=1, with a latency of 1 cycle. Also run WIDTH=8, CHUNK=1 against a random reference model for 1000 ops.
